// File: rtl/adc_sample_averager.sv
// adc_sample_averager: SAR conversion sequencer with power-of-two sample averaging
module adc_sample_averager #(
  parameter int DATA_W     = 8,
  parameter int AVG_LOG2   = 2,
  parameter int INTERVAL_W = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [INTERVAL_W-1:0] interval,
  output logic                  adc_start,
  input  logic                  adc_busy,
  input  logic                  adc_valid,
  input  logic [DATA_W-1:0]     adc_data,
  output logic [DATA_W-1:0]     avg_data,
  output logic                  avg_valid,
  input  logic                  avg_ready,
  output logic                  overrun,
  output logic                  timeout_err
);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, START, CONVERT} state_t;
  state_t                state, state_nx;
  logic [INTERVAL_W-1:0] tick_cnt, period_q, lim, lim_m1;
  logic                  tick_pending, wrap;
  logic [TO_W-1:0]       to_cnt;
  logic                  adc_valid_q, rise, capture, tmo, start_go, last, load;
  logic [ACC_W-1:0]      acc, sum;
  logic [AVG_LOG2-1:0]   count;
  logic                  unused_busy;
  assign unused_busy = adc_busy;
  // Period limit: live interval on the first enabled cycle, then the value latched at each wrap
  always_comb begin
    lim    = (state == IDLE) ? interval : period_q;
    lim_m1 = (lim == '0) ? '0 : lim - INTERVAL_W'(1);
    wrap   = enable && (tick_cnt >= lim_m1);
  end
  // Tick counter and single collapsed pending tick; a fresh wrap outranks the clear on START entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt     <= '0;
      period_q     <= '0;
      tick_pending <= 1'b0;
    end else if (!enable) begin
      tick_cnt     <= '0;
      tick_pending <= 1'b0;
    end else begin
      tick_cnt     <= wrap ? '0 : tick_cnt + INTERVAL_W'(1);
      period_q     <= (wrap || state == IDLE) ? interval : period_q;
      tick_pending <= wrap || (tick_pending && !start_go);
    end
  end
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  // Next-state logic; dropping enable aborts from any state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = WAIT;
      WAIT:    state_nx = tick_pending ? START : WAIT;
      START:   state_nx = CONVERT;
      CONVERT: state_nx = (capture || tmo) ? WAIT : CONVERT;
      default: state_nx = IDLE;
    endcase
    if (!enable) state_nx = IDLE;
  end
  // Decoded events: valid rising edge, capture, timeout, start request, final sample of a group
  always_comb begin
    rise     = adc_valid && !adc_valid_q;
    start_go = (state == WAIT) && tick_pending;
    capture  = enable && (state == CONVERT) && rise;
    tmo      = enable && (state == CONVERT) && !rise && (to_cnt == TO_W'(TIMEOUT - 1));
    last     = count == '1;
    sum      = acc + ACC_W'(adc_data);
    load     = capture && last;
  end
  // Registered start pulse from the START state, plus valid edge history and conversion timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_start   <= 1'b0;
      adc_valid_q <= 1'b0;
      to_cnt      <= '0;
    end else begin
      adc_start   <= enable && (state == START);
      adc_valid_q <= adc_valid;
      to_cnt      <= (enable && state == CONVERT) ? to_cnt + TO_W'(1) : '0;
    end
  end
  // Accumulator and sample count; cleared on the group's final capture and while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
    end else if (!enable) begin
      acc   <= '0;
      count <= '0;
    end else if (capture) begin
      acc   <= last ? '0 : sum;
      count <= count + AVG_LOG2'(1);
    end
  end
  // Output handshake: load when the slot is free or being drained, otherwise drop and flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_data  <= '0;
      avg_valid <= 1'b0;
    end else if (load && (!avg_valid || avg_ready)) begin
      avg_data  <= DATA_W'(sum >> AVG_LOG2);
      avg_valid <= 1'b1;
    end else if (avg_ready) begin
      avg_valid <= 1'b0;
    end
  end
  // Sticky error flags, held clear while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      overrun     <= enable && (overrun || (load && avg_valid && !avg_ready));
      timeout_err <= enable && (timeout_err || tmo);
    end
  end
endmodule

// File: tb/tb_adc_sample_averager.sv
// tb_adc_sample_averager: directed and randomized checks of the ADC averager against a SAR model
module tb_adc_sample_averager;
  localparam int TMO = 64;
  logic        clk = 1'b0;
  logic        rst_n, enable, adc_start, adc_busy, adc_valid, avg_valid, avg_ready, overrun, timeout_err;
  logic [15:0] interval;
  logic [7:0]  adc_data, avg_data;
  int checks = 0, errors = 0, cyc = 0, delivered = 0, mode = 0, lat = 5, rem = 0, cur = 0;
  int code_q[$], start_q[$], out_q[$], sent[$];
  int e0, s, n, b, k;
  adc_sample_averager dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .interval(interval),
    .adc_start(adc_start), .adc_busy(adc_busy), .adc_valid(adc_valid), .adc_data(adc_data),
    .avg_data(avg_data), .avg_valid(avg_valid), .avg_ready(avg_ready),
    .overrun(overrun), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  // SAR model: mode 0 answers after lat cycles with a level valid, mode 1 never answers, mode 2 is inert
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n && adc_start && mode != 2) begin
      adc_valid = 1'b0;
      adc_busy  = 1'b1;
      rem       = (mode == 0) ? lat : 0;
      cur       = 0;
      if (mode == 0 && code_q.size() > 0) cur = code_q.pop_front();
    end else if (adc_busy && mode == 0 && rem > 0) begin
      rem--;
      if (rem == 0) begin
        adc_valid = 1'b1;
        adc_data  = 8'(cur);
        adc_busy  = 1'b0;
        delivered++;
      end
    end
  end
  // Monitor: start pulse cycles and accepted averages
  initial forever begin
    @(negedge clk);
    #3;
    if (adc_start) start_q.push_back(cyc);
    if (rst_n && avg_valid && avg_ready) out_q.push_back(int'(avg_data));
  end
  task automatic step();
    @(negedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wait_cap(input int target);
    int w = 0;
    while (delivered < target && w < 3000) begin
      step();
      w++;
    end
    chk("capture_wait", delivered >= target, 1);
    repeat (2) step();
  endtask
  task automatic wait_start(input int idx);
    int w = 0;
    while (start_q.size() <= idx && w < 500) begin
      step();
      w++;
    end
    chk("start_wait", start_q.size() > idx, 1);
  endtask
  task automatic flush();
    code_q.delete();
    start_q.delete();
    out_q.delete();
    adc_valid = 1'b0;
    adc_busy  = 1'b0;
    rem       = 0;
    delivered = 0;
  endtask
  function automatic int avg4(input int q[$], input int g);
    int sm = 0;
    for (int i = 0; i < 4; i++) sm += q[4 * g + i];
    return sm / 4;
  endfunction
  initial begin
    rst_n = 1'b0; enable = 1'b0; interval = 16'd20; avg_ready = 1'b1;
    adc_busy = 1'b0; adc_valid = 1'b0; adc_data = 8'd0;
    repeat (3) step();
    chk("rst_adc_start", adc_start, 0);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_avg_data", avg_data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    step();
    // Constant and directed codes at interval 20
    flush();
    sent = {100, 100, 100, 100, 100, 100, 100, 100, 10, 11, 12, 13, 255, 255, 255, 255};
    code_q = sent;
    e0 = cyc;
    enable = 1'b1;
    wait_cap(16);
    chk("first_start", start_q[0], e0 + 22);
    for (int i = 1; i < start_q.size(); i++) chk($sformatf("spacing_%0d", i), start_q[i] - start_q[i-1], 20);
    chk("avg_count", out_q.size(), 4);
    chk("avg_100_a", out_q[0], 100);
    chk("avg_100_b", out_q[1], 100);
    chk("avg_10_13", out_q[2], 11);
    chk("avg_255", out_q[3], 255);
    enable = 1'b0;
    repeat (3) step();
    // Random interval, latency and codes
    flush();
    n = $urandom_range(8, 40);
    lat = $urandom_range(1, n - 4);
    interval = 16'(n);
    sent.delete();
    for (int i = 0; i < 16; i++) sent.push_back($urandom_range(0, 255));
    code_q = sent;
    e0 = cyc;
    enable = 1'b1;
    wait_cap(16);
    chk("rand_first_start", start_q[0], e0 + n + 2);
    for (int i = 1; i < start_q.size(); i++) chk($sformatf("rand_spacing_%0d", i), start_q[i] - start_q[i-1], n);
    chk("rand_avg_count", out_q.size(), 4);
    for (int g = 0; g < 4; g++) chk($sformatf("rand_avg_%0d", g), out_q[g], avg4(sent, g));
    enable = 1'b0;
    repeat (3) step();
    // Back-pressure and overrun
    flush();
    interval = 16'd20; lat = 5; avg_ready = 1'b0;
    code_q = {40, 40, 40, 40, 80, 80, 80, 80};
    enable = 1'b1;
    wait_cap(4);
    chk("bp_valid", avg_valid, 1);
    chk("bp_data_first", avg_data, 40);
    chk("bp_no_overrun", overrun, 0);
    wait_cap(8);
    chk("bp_data_held", avg_data, 40);
    chk("bp_overrun", overrun, 1);
    avg_ready = 1'b1;
    step();
    chk("bp_accept_clear", avg_valid, 0);
    chk("bp_accept_count", out_q.size(), 1);
    chk("bp_accept_data", out_q[0], 40);
    enable = 1'b0;
    repeat (2) step();
    chk("overrun_clear", overrun, 0);
    // Conversion timeout, then normal conversions resume
    flush();
    interval = 16'd100; mode = 1;
    enable = 1'b1;
    wait_start(0);
    s = start_q[0];
    b = 0;
    while (!timeout_err && b < 300) begin step(); b++; end
    chk("timeout_cycle", cyc, s + TMO);
    mode = 0;
    sent.delete();
    for (int i = 0; i < 4; i++) sent.push_back($urandom_range(0, 255));
    code_q = sent;
    wait_cap(4);
    chk("timeout_next_start", start_q[1], s + 100);
    chk("timeout_avg", out_q[0], avg4(sent, 0));
    chk("timeout_sticky", timeout_err, 1);
    enable = 1'b0;
    repeat (2) step();
    chk("timeout_clear", timeout_err, 0);
    // Stale valid level is never re-captured
    flush();
    mode = 2; adc_valid = 1'b1; adc_data = 8'd77; interval = 16'd20;
    enable = 1'b1;
    wait_start(0);
    s = start_q[0];
    b = 0;
    while (!timeout_err && b < 300) begin step(); b++; end
    chk("stale_timeout_cycle", cyc, s + TMO);
    chk("stale_no_avg", avg_valid, 0);
    enable = 1'b0;
    repeat (2) step();
    mode = 0;
    // Partial group discarded by enable drop
    flush();
    code_q = {$urandom_range(0, 255), $urandom_range(0, 255)};
    enable = 1'b1;
    wait_cap(2);
    enable = 1'b0;
    repeat (3) step();
    chk("partial_no_output", out_q.size(), 0);
    chk("partial_no_valid", avg_valid, 0);
    sent.delete();
    for (int i = 0; i < 4; i++) sent.push_back($urandom_range(0, 255));
    code_q = sent;
    k = start_q.size();
    e0 = cyc;
    enable = 1'b1;
    wait_cap(6);
    chk("reenable_first_start", start_q[k], e0 + 22);
    chk("reenable_avg_count", out_q.size(), 1);
    chk("reenable_avg", out_q[0], avg4(sent, 0));
    // Asynchronous reset during a conversion with an average pending
    avg_ready = 1'b0;
    for (int i = 0; i < 5; i++) code_q.push_back($urandom_range(4, 255));
    wait_cap(10);
    chk("pre_reset_pending", avg_valid, 1);
    b = 0;
    while (adc_start !== 1'b1 && b < 100) begin step(); b++; end
    chk("pre_reset_start_seen", adc_start, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_adc_start", adc_start, 0);
    chk("mid_rst_avg_valid", avg_valid, 0);
    chk("mid_rst_avg_data", avg_data, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_timeout_err", timeout_err, 0);
    step();
    flush();
    sent.delete();
    for (int i = 0; i < 4; i++) sent.push_back($urandom_range(0, 255));
    code_q = sent;
    avg_ready = 1'b1;
    e0 = cyc;
    rst_n = 1'b1;
    wait_cap(4);
    chk("post_rst_first_start", start_q[0], e0 + 22);
    chk("post_rst_avg", out_q[0], avg4(sent, 0));
    enable = 1'b0;
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
